// File: rtl/disp_mux_drv_if.sv
// Display scanner bus: formatted digit data and enables in, segment/select pin drive out.
// The scanner uses the slave modport; the value-formatting side uses master.
interface disp_mux_drv_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_WIDTH  = 8,
  parameter int BRIGHT_W   = 4
);
  logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_in;
  logic [NUM_DIGITS-1:0]           dig_en;
  logic [BRIGHT_W-1:0]             brightness;
  logic [SEG_WIDTH-1:0]            dig_val;
  logic [NUM_DIGITS-1:0]           dig_sel;
  logic                            frame_tick;

  modport master (
    output seg_in, dig_en, brightness,
    input  dig_val, dig_sel, frame_tick
  );

  modport slave (
    input  seg_in, dig_en, brightness,
    output dig_val, dig_sel, frame_tick
  );
endinterface

// File: rtl/disp_mux_drv.sv
// Round-robin multi-digit display scanner with per-slot blanking gap and PWM on-time.
// Latency: select asserts BLANK_CYCLES+1 cycles after slot start; no backpressure, outputs free-run.
module disp_mux_drv #(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_WIDTH      = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int BRIGHT_W       = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic           clock,
  input  logic           reset_n,
  disp_mux_drv_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = CW + BRIGHT_W + 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON, ST_OFF} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_slot_cnt;
  logic [IW-1:0]         r_idx;
  logic [SEG_WIDTH-1:0]  r_seg;
  logic [PW-1:0]         r_on_len;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [SEG_WIDTH-1:0]  r_val;
  logic                  r_tick;

  logic [PW-1:0]         w_prod;
  logic [PW-1:0]         w_shift;
  logic [PW-1:0]         w_on_len;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_has_up;
  logic [IW-1:0]         w_up_idx;
  logic [IW-1:0]         w_low_idx;
  logic [IW-1:0]         w_start_idx;
  logic [SEG_WIDTH-1:0]  w_start_seg;
  state_t                w_phase;
  state_t                w_start_state;

  // Full-width product so the top brightness code yields exactly REFRESH_DIV-BLANK_CYCLES.
  assign w_prod   = PW'(REFRESH_DIV - BLANK_CYCLES) * (PW'(bus.brightness) + PW'(1));
  assign w_shift  = w_prod >> BRIGHT_W;
  assign w_on_len = (w_shift == '0) ? PW'(1) : w_shift;

  assign w_cnt_inc     = r_slot_cnt + CW'(1);
  assign w_start_state = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  always_comb begin
    w_has_up  = 1'b0;
    w_up_idx  = '0;
    w_low_idx = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (bus.dig_en[k]) begin
        w_low_idx = IW'(k);
        if (IW'(k) > r_idx) begin
          w_has_up = 1'b1;
          w_up_idx = IW'(k);
        end
      end
    end
  end

  assign w_start_idx = (r_state == ST_IDLE || !w_has_up) ? w_low_idx : w_up_idx;
  assign w_start_seg = bus.seg_in[w_start_idx*SEG_WIDTH +: SEG_WIDTH];

  always_comb begin
    w_phase = ST_OFF;
    if (PW'(w_cnt_inc) < PW'(BLANK_CYCLES))
      w_phase = ST_BLANK;
    else if (PW'(w_cnt_inc) < PW'(BLANK_CYCLES) + r_on_len)
      w_phase = ST_ON;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_slot_cnt <= '0;
      r_idx      <= '0;
      r_seg      <= '0;
      r_on_len   <= '0;
      r_sel      <= '0;
      r_val      <= '0;
      r_tick     <= 1'b0;
    end else begin
      // Pin drive lags the phase state by one cycle.
      r_sel  <= (r_state == ST_ON) ? (NUM_DIGITS'(1) << r_idx) : '0;
      r_val  <= (r_state == ST_IDLE) ? '0 : r_seg;
      r_tick <= 1'b0;
      if (r_state == ST_IDLE || r_slot_cnt == LAST) begin
        r_slot_cnt <= '0;
        if (bus.dig_en == '0) begin
          r_state <= ST_IDLE;
        end else begin
          r_state  <= w_start_state;
          r_idx    <= w_start_idx;
          r_seg    <= w_start_seg;
          r_on_len <= w_on_len;
          r_tick   <= (r_state == ST_IDLE) || !w_has_up;
        end
      end else begin
        r_slot_cnt <= w_cnt_inc;
        r_state    <= w_phase;
      end
    end
  end

  assign bus.dig_sel    = r_sel ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
  assign bus.dig_val    = r_val ^ {SEG_WIDTH{SEG_ACTIVE_LOW}};
  assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_disp_mux_drv.sv
// Bench for disp_mux_drv: directed scan scenarios, each ON burst scored against a queue of
// expected (select, segments, length, frame tick, preceding gap) records.
module tb_disp_mux_drv;
  localparam int ND = 4;
  localparam int SW = 8;
  localparam int BW = 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  disp_mux_drv_if #(.NUM_DIGITS(ND), .SEG_WIDTH(SW), .BRIGHT_W(BW)) bus ();

  disp_mux_drv #(
    .NUM_DIGITS(ND), .SEG_WIDTH(SW), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .BRIGHT_W(BW), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [3:0] sel;
    logic [7:0] val;
    int         len;
    bit         tick;
    int         gap;   // -1: gap not predictable (after reset or idle)
  } burst_t;

  burst_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [3:0] s, input logic [7:0] v, input int l,
                               input bit t, input int g);
    burst_t e;
    e.sel = s; e.val = v; e.len = l; e.tick = t; e.gap = g;
    exp_q.push_back(e);
  endfunction

  // Monitor state
  int         cyc = 0;
  int         gap = -1;
  int         tick_cyc = 0;
  bit         in_b = 1'b0;
  bit         tick_seen = 1'b0;
  bit         val_bad = 1'b0;
  logic [3:0] b_sel;
  logic [7:0] b_val;
  int         b_len, b_gap, b_lat;
  bit         b_tick;

  task automatic close_burst();
    burst_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_burst: sel %b val 0x%0h len %0d, expected none", b_sel, b_val, b_len);
    end else begin
      e = exp_q.pop_front();
      chk("burst_sel", b_sel, e.sel);
      chk("burst_val", b_val, e.val);
      chk("burst_len", b_len, e.len);
      chk("burst_tick", b_tick, e.tick);
      if (e.gap >= 0) chk("burst_gap", b_gap, e.gap);
      if (b_tick) chk("tick_to_sel_latency", b_lat, 3);
      chk("burst_val_stable", val_bad, 0);
    end
  endtask

  initial forever begin
    @(negedge clock);
    cyc++;
    if (!reset_n) begin
      in_b = 1'b0;
      gap = -1;
      tick_seen = 1'b0;
    end else begin
      if (bus.frame_tick) begin
        tick_seen = 1'b1;
        tick_cyc = cyc;
      end
      if (in_b && bus.dig_sel != b_sel) begin
        close_burst();
        in_b = 1'b0;
        gap = 0;
      end
      if (!in_b) begin
        if (bus.dig_sel != '0) begin
          in_b = 1'b1;
          b_sel = bus.dig_sel;
          b_val = bus.dig_val;
          b_len = 1;
          b_gap = gap;
          b_tick = tick_seen;
          b_lat = cyc - tick_cyc;
          tick_seen = 1'b0;
          val_bad = 1'b0;
        end else if (gap >= 0) begin
          gap++;
        end
      end else begin
        b_len++;
        if (bus.dig_val != b_val) val_bad = 1'b1;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, %0d bursts outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_first_frame();
    push(4'b0001, 8'h11, 6, 1, -1);
    push(4'b0010, 8'h22, 6, 0, 2);
    push(4'b0100, 8'h44, 6, 0, 2);
    push(4'b1000, 8'h88, 6, 0, 2);
    push(4'b0001, 8'h11, 6, 1, 2);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.seg_in = {8'h88, 8'h44, 8'h22, 8'h11};
    bus.dig_en = 4'b1111;
    bus.brightness = 2'd3;
    step(3);
    chk("reset_dig_sel", bus.dig_sel, 0);
    chk("reset_dig_val", bus.dig_val, 0);
    chk("reset_frame_tick", bus.frame_tick, 0);

    // Full scan (slots every 8 cycles from cycle 1), then mid-slot change on slot 65.
    push_first_frame();
    push(4'b0010, 8'h22, 6, 0, 2);
    push(4'b0100, 8'h44, 6, 0, 2);
    push(4'b1000, 8'h88, 6, 0, 2);
    push(4'b0001, 8'h11, 6, 1, 2);
    // Brightness 0 from slot 73
    push(4'b0010, 8'h22, 1, 0, 2);
    push(4'b0100, 8'h44, 1, 0, 7);
    push(4'b1000, 8'h88, 1, 0, 7);
    push(4'b0001, 8'hFF, 1, 1, 7);
    // Brightness 1 from slot 105
    push(4'b0010, 8'h22, 3, 0, 7);
    push(4'b0100, 8'h44, 3, 0, 5);
    push(4'b1000, 8'h88, 3, 0, 5);
    push(4'b0001, 8'hFF, 3, 1, 5);
    // Skip mask 1010 from slot 137
    push(4'b0010, 8'h22, 6, 0, 5);
    push(4'b1000, 8'h88, 6, 0, 2);
    push(4'b0010, 8'h22, 6, 1, 2);
    push(4'b1000, 8'h88, 6, 0, 2);
    push(4'b0010, 8'h22, 6, 1, 2);
    push(4'b1000, 8'h88, 6, 0, 2);
    // Single digit 2 after idle
    push(4'b0100, 8'h44, 6, 1, -1);
    push(4'b0100, 8'h44, 6, 1, 2);

    reset_n = 1'b1;            // cycle 0
    step(68);
    bus.seg_in[7:0] = 8'hFF;
    bus.brightness = 2'd0;
    step(32);                  // cycle 100
    bus.brightness = 2'd1;
    step(32);                  // cycle 132
    bus.dig_en = 4'b1010;
    bus.brightness = 2'd3;
    step(48);                  // cycle 180
    bus.dig_en = 4'b0000;
    step(8);
    chk("idle_dig_sel_a", bus.dig_sel, 0);
    chk("idle_dig_val_a", bus.dig_val, 0);
    chk("idle_frame_tick_a", bus.frame_tick, 0);
    step(3);
    chk("idle_dig_sel_b", bus.dig_sel, 0);
    chk("idle_dig_val_b", bus.dig_val, 0);
    step(4);                   // cycle 195
    bus.dig_en = 4'b0100;
    step(22);                  // cycle 217, digit-2 ON phase
    chk("pre_reset_dig_sel", bus.dig_sel, 4'b0100);
    chk("pre_reset_queue_drained", exp_q.size(), 0);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_dig_sel", bus.dig_sel, 0);
    chk("async_reset_dig_val", bus.dig_val, 0);
    chk("async_reset_frame_tick", bus.frame_tick, 0);

    bus.seg_in = {8'h88, 8'h44, 8'h22, 8'h11};
    bus.dig_en = 4'b1111;
    bus.brightness = 2'd3;
    push_first_frame();
    step(3);
    reset_n = 1'b1;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
